// File: rtl/subtractor_share_arbiter.sv
// Round-robin arbiter that lends one limb-serial subtractor to two requesters,
// one whole number at a time, and routes the result limbs back to the owner.

module great_subtractor #(
   parameter int REGISTER_SIZE = 32
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     valid_in,
   input  logic                     last_in,
   input  logic [REGISTER_SIZE-1:0] a_in,
   input  logic [REGISTER_SIZE-1:0] b_in,
   output logic [REGISTER_SIZE-1:0] data_out,
   output logic                     valid_out,
   output logic                     final_out
);

   logic                   borrow;
   logic [REGISTER_SIZE:0] diff;

   assign diff = {1'b0, a_in} - {1'b0, b_in} - {{REGISTER_SIZE{1'b0}}, borrow};

   // The borrow is dropped after the MS limb so each number starts clean.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         borrow    <= 1'b0;
         data_out  <= '0;
         valid_out <= 1'b0;
         final_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         final_out <= valid_in & last_in;
         if (valid_in) begin
            data_out <= diff[REGISTER_SIZE-1:0];
            borrow   <= last_in ? 1'b0 : diff[REGISTER_SIZE];
         end
      end
   end

endmodule

// state  | meaning
// IDLE   | no owner; arbitrate pending requests
// STREAM | granted client's limbs are forwarded to the subtractor
// DRAIN  | all limbs accepted; waiting for the final result limb
module subtractor_share_arbiter #(
   parameter int REGISTER_SIZE = 32,
   parameter int BITS_IN_NUM   = 2048
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic [1:0]               req_in,
   input  logic [1:0]               valid_in,
   input  logic [REGISTER_SIZE-1:0] a0_in,
   input  logic [REGISTER_SIZE-1:0] b0_in,
   input  logic [REGISTER_SIZE-1:0] a1_in,
   input  logic [REGISTER_SIZE-1:0] b1_in,
   output logic [1:0]               grant_out,
   output logic [REGISTER_SIZE-1:0] data_out,
   output logic [1:0]               valid_out,
   output logic [1:0]               final_out,
   output logic                     busy_out
);

   localparam int LIMBS = BITS_IN_NUM / REGISTER_SIZE;
   localparam int CW    = $clog2(LIMBS + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t                   state;
   logic                     ptr;
   logic                     owner;
   logic                     pick;
   logic [CW-1:0]            count;
   logic                     accept;
   logic                     last_limb;
   logic [REGISTER_SIZE-1:0] sub_a;
   logic [REGISTER_SIZE-1:0] sub_b;
   logic [REGISTER_SIZE-1:0] sub_data;
   logic                     sub_valid;
   logic                     sub_final;

   // grant_out is only non-zero in STREAM, so this also qualifies the state.
   assign accept    = |(valid_in & grant_out);
   assign last_limb = accept && (count == CW'(LIMBS - 1));
   assign pick      = req_in[ptr] ? ptr : ~ptr;
   assign sub_a     = owner ? a1_in : a0_in;
   assign sub_b     = owner ? b1_in : b0_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= IDLE;
         grant_out <= 2'b00;
         busy_out  <= 1'b0;
         count     <= '0;
         ptr       <= 1'b0;
         owner     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_in) begin
                  owner     <= pick;
                  grant_out <= pick ? 2'b10 : 2'b01;
                  busy_out  <= 1'b1;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (last_limb) begin
                  grant_out <= 2'b00;
                  count     <= '0;
                  state     <= DRAIN;
               end else if (accept) begin
                  count <= count + 1'b1;
               end
            end
            DRAIN: begin
               if (sub_final) begin
                  ptr      <= ~owner;
                  busy_out <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   great_subtractor #(.REGISTER_SIZE(REGISTER_SIZE)) u_sub (
      .clk_in   (clk_in),
      .rst_in   (~rst_n_in),
      .valid_in (accept),
      .last_in  (last_limb),
      .a_in     (sub_a),
      .b_in     (sub_b),
      .data_out (sub_data),
      .valid_out(sub_valid),
      .final_out(sub_final)
   );

   // Owner tag is stable until the next grant, which is always after DRAIN.
   assign data_out  = sub_data;
   assign valid_out = {sub_valid & owner, sub_valid & ~owner};
   assign final_out = {sub_final & owner, sub_final & ~owner};

endmodule

// File: tb/tb_subtractor_share_arbiter.sv
// Directed bench for subtractor_share_arbiter with 128-bit numbers (4 limbs):
// arbitration order, limb accounting, result routing and reset abort.

module tb_subtractor_share_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [1:0]  req_in;
   logic [1:0]  valid_in;
   logic [31:0] a0_in, b0_in, a1_in, b1_in;
   logic [1:0]  grant_out;
   logic [31:0] data_out;
   logic [1:0]  valid_out;
   logic [1:0]  final_out;
   logic        busy_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [32:0]  q0[$];
   logic [32:0]  q1[$];
   int           fin_order[$];
   int           stray = 0;
   logic [127:0] opa[2][2];
   logic [127:0] opb[2][2];

   subtractor_share_arbiter #(.REGISTER_SIZE(32), .BITS_IN_NUM(128)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .req_in   (req_in),
      .valid_in (valid_in),
      .a0_in    (a0_in),
      .b0_in    (b0_in),
      .a1_in    (a1_in),
      .b1_in    (b1_in),
      .grant_out(grant_out),
      .data_out (data_out),
      .valid_out(valid_out),
      .final_out(final_out),
      .busy_out (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Result recorder: {final, data} per client plus the order of finals.
   always @(negedge clk_in) begin
      if (rst_n_in) begin
         if (valid_out[0]) q0.push_back({final_out[0], data_out});
         if (valid_out[1]) q1.push_back({final_out[1], data_out});
         if (final_out[0]) fin_order.push_back(0);
         if (final_out[1]) fin_order.push_back(1);
         if ((final_out & ~valid_out) != 2'b00 || valid_out == 2'b11) stray++;
      end
   end

   task automatic clear_rec();
      q0.delete();
      q1.delete();
      fin_order.delete();
      stray = 0;
   endtask

   task automatic pulse_reset();
      @(negedge clk_in);
      rst_n_in = 1'b0;
      req_in   = 2'b00;
      valid_in = 2'b00;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      clear_rec();
   endtask

   // Clients act as sequencers; a non-granted client always drives junk
   // with valid high, which must never reach the subtractor.
   task automatic run_ops(input int ops0, input int ops1, input logic [15:0] pat1,
                          input int max_cyc);
      int   left[2];
      int   li[2];
      int   pi[2];
      int   k[2];
      bit   done_now[2];
      int   cyc;
      int   bad;
      logic v;
      logic [31:0] la, lb;
      left[0] = ops0; left[1] = ops1;
      for (int c = 0; c < 2; c++) begin
         li[c] = 0; pi[c] = 0; k[c] = 0; done_now[c] = 1'b0;
      end
      cyc = 0;
      bad = 0;
      while ((left[0] > 0 || left[1] > 0) && cyc < max_cyc) begin
         @(negedge clk_in);
         cyc++;
         if (grant_out == 2'b11 || (grant_out != 2'b00 && !busy_out)) bad++;
         for (int c = 0; c < 2; c++) begin
            if (grant_out[c] && done_now[c]) bad++;
            done_now[c] = 1'b0;
            if (grant_out[c]) begin
               v = (c == 1) ? pat1[pi[c] % 16] : 1'b1;
               pi[c]++;
               la = opa[c][k[c]][li[c]*32 +: 32];
               lb = opb[c][k[c]][li[c]*32 +: 32];
               if (v) begin
                  li[c]++;
                  if (li[c] == 4) begin
                     li[c] = 0; k[c]++; left[c]--; pi[c] = 0; done_now[c] = 1'b1;
                  end
               end
               req_in[c] = 1'b0;
            end else begin
               v  = 1'b1;
               la = 32'hDEADBEEF;
               lb = 32'h0BADF00D;
               req_in[c] = (left[c] > 0);
            end
            valid_in[c] = v;
            if (c == 0) begin a0_in = la; b0_in = lb; end
            else begin a1_in = la; b1_in = lb; end
         end
      end
      repeat (4) begin
         @(negedge clk_in);
         if (grant_out != 2'b00) bad++;
         req_in   = 2'b00;
         valid_in = 2'b11;
      end
      valid_in = 2'b00;
      n_cmp++;
      if (cyc >= max_cyc) begin
         n_bad++;
         $display("FAIL run_timeout cycles %0d reached limit %0d", cyc, max_cyc);
      end
      n_cmp++;
      if (bad !== 0 || stray !== 0) begin
         n_bad++;
         $display("FAIL grant_protocol violations %0d stray strobes %0d, want 0/0", bad, stray);
      end
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      req_in   = 2'b11;
      valid_in = 2'b11;
      a0_in = 32'h1; b0_in = 32'h0; a1_in = 32'h1; b1_in = 32'h0;
      repeat (3) @(negedge clk_in);
      n_cmp++;
      if ({grant_out, valid_out, final_out, busy_out, data_out} !== 39'h0) begin
         n_bad++;
         $display("FAIL reset_outputs got g=%b v=%b f=%b busy=%b d=%h want all 0",
                  grant_out, valid_out, final_out, busy_out, data_out);
      end
      req_in   = 2'b00;
      valid_in = 2'b00;
      rst_n_in = 1'b1;
      clear_rec();
   endtask

   task automatic test_single();
      logic [31:0] exp_l[4];
      logic [32:0] got, exp;
      exp_l[0] = 32'hFFFFFFFF; exp_l[1] = 32'hFFFFFFFF;
      exp_l[2] = 32'hFFFFFFFF; exp_l[3] = 32'h00000004;
      opa[0][0] = 128'h5_00000000_00000000_00000003;
      opb[0][0] = 128'h4;
      run_ops(1, 0, 16'hFFFF, 200);
      n_cmp++;
      if (q0.size() !== 4 || q1.size() !== 0) begin
         n_bad++;
         $display("FAIL single_count got c0=%0d c1=%0d want 4/0", q0.size(), q1.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < q0.size()) ? q0[i] : 33'h0;
         exp = {(i == 3), exp_l[i]};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL single_limb%0d got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_both_rerequest();
      logic [127:0] d;
      logic [32:0]  got, exp;
      pulse_reset();
      opa[0][0] = 128'h00000010_00000000_00000001_00000000;
      opb[0][0] = 128'h00000001_00000000_00000000_00000001;
      opa[0][1] = 128'h22222222_33333333_44444444_55555555;
      opb[0][1] = 128'h11111111_11111111_11111111_11111111;
      opa[1][0] = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
      opb[1][0] = 128'h00000000_00000001_00000000_00000002;
      run_ops(2, 1, 16'hFFFF, 300);
      n_cmp++;
      if (fin_order.size() !== 3 || fin_order[0] !== 0 || fin_order[1] !== 1 ||
          fin_order[2] !== 0) begin
         n_bad++;
         $display("FAIL both_order got %0d finals (%0d,%0d,%0d) want 3 (0,1,0)",
                  fin_order.size(), fin_order[0], fin_order[1], fin_order[2]);
      end
      n_cmp++;
      if (q0.size() !== 8 || q1.size() !== 4) begin
         n_bad++;
         $display("FAIL both_count got c0=%0d c1=%0d want 8/4", q0.size(), q1.size());
      end
      for (int i = 0; i < 8; i++) begin
         d   = opa[0][i/4] - opb[0][i/4];
         exp = {(i % 4 == 3), d[(i%4)*32 +: 32]};
         got = (i < q0.size()) ? q0[i] : 33'h0;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL both_c0_limb%0d got %h want %h", i, got, exp);
         end
      end
      for (int i = 0; i < 4; i++) begin
         d   = opa[1][0] - opb[1][0];
         exp = {(i == 3), d[i*32 +: 32]};
         got = (i < q1.size()) ? q1[i] : 33'h0;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL both_c1_limb%0d got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_gaps();
      logic [127:0] d;
      logic [32:0]  got, exp;
      clear_rec();
      opa[1][0] = 128'h00000009_00000008_00000007_00000006;
      opb[1][0] = 128'h00000001_00000002_00000003_00000004;
      run_ops(0, 1, 16'hFFD9, 200);
      n_cmp++;
      if (q1.size() !== 4 || q0.size() !== 0) begin
         n_bad++;
         $display("FAIL gaps_count got c1=%0d c0=%0d want 4/0", q1.size(), q0.size());
      end
      d = opa[1][0] - opb[1][0];
      for (int i = 0; i < 4; i++) begin
         exp = {(i == 3), d[i*32 +: 32]};
         got = (i < q1.size()) ? q1[i] : 33'h0;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL gaps_limb%0d got %h want %h", i, got, exp);
         end
      end
   endtask

   task automatic test_equal();
      logic [32:0] got;
      clear_rec();
      opa[0][0] = {$urandom, $urandom, $urandom, $urandom};
      opb[0][0] = opa[0][0];
      run_ops(1, 0, 16'hFFFF, 200);
      n_cmp++;
      if (q0.size() !== 4 || q1.size() !== 0) begin
         n_bad++;
         $display("FAIL equal_count got c0=%0d c1=%0d want 4/0", q0.size(), q1.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < q0.size()) ? q0[i] : 33'h1_FFFFFFFF;
         n_cmp++;
         if (got !== {(i == 3), 32'h0}) begin
            n_bad++;
            $display("FAIL equal_limb%0d got %h want %h", i, got, {(i == 3), 32'h0});
         end
      end
   endtask

   task automatic test_abort();
      int          w;
      logic [32:0] got, exp;
      pulse_reset();
      @(negedge clk_in);
      req_in = 2'b01;
      w = 0;
      while (!grant_out[0] && w < 10) begin
         @(negedge clk_in);
         w++;
      end
      n_cmp++;
      if (!grant_out[0]) begin
         n_bad++;
         $display("FAIL abort_grant got %b want 01", grant_out);
      end
      req_in   = 2'b00;
      valid_in = 2'b01;
      a0_in = 32'h0; b0_in = 32'h1;
      @(negedge clk_in);
      a0_in = 32'h0; b0_in = 32'h0;
      @(negedge clk_in);
      valid_in = 2'b00;
      n_cmp++;
      if (busy_out !== 1'b1 || valid_out !== 2'b01) begin
         n_bad++;
         $display("FAIL abort_midway got busy=%b v=%b want 1/01", busy_out, valid_out);
      end
      #2 rst_n_in = 1'b0;
      #1;
      n_cmp++;
      if ({grant_out, valid_out, final_out, busy_out, data_out} !== 39'h0) begin
         n_bad++;
         $display("FAIL abort_async got g=%b v=%b f=%b busy=%b d=%h want all 0",
                  grant_out, valid_out, final_out, busy_out, data_out);
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      clear_rec();
      opa[0][0] = 128'h9;
      opb[0][0] = 128'h2;
      run_ops(1, 0, 16'hFFFF, 200);
      n_cmp++;
      if (q0.size() !== 4) begin
         n_bad++;
         $display("FAIL abort_count got %0d want 4", q0.size());
      end
      for (int i = 0; i < 4; i++) begin
         exp = {(i == 3), (i == 0) ? 32'h7 : 32'h0};
         got = (i < q0.size()) ? q0[i] : 33'h0;
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL abort_next_limb%0d got %h want %h", i, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_both_rerequest();
      test_gaps();
      test_equal();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
